soc_msp430_dmem_arbiter: RTL and testbench

//  Two-requester arbiter sharing one single-port data memory between two MSP430

---
 rtl/soc_msp430_dmem_arb_pkg.sv | 14 +
 rtl/soc_msp430_dmem_rdhold.sv | 36 +++
 rtl/soc_msp430_dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_soc_msp430_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/soc_msp430_dmem_arb_pkg.sv
// Shared types and constants for the two-core data-memory arbiter.
//   arb_state_t : ownership state of the shared DMEM port
//   WEN_READ    : byte write-enable pattern that denotes a read access
package soc_msp430_dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] WEN_READ = 2'b11;

endpackage

// File: rtl/soc_msp430_dmem_rdhold.sv
// Per-core read-return steering and hold register.
// A read granted in cycle N returns from the macro in cycle N+1; rd_pend_q marks that cycle so the
// core sees live macro data, and the hold register keeps it afterwards so later accesses by the
// other core cannot disturb this core's dout.
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active high (drops any pending return)
//   rd_issue_i   read granted to this core in the current cycle
//   mem_rdata_i  read data from the DMEM macro
//   dout_o       read data presented to the core
module soc_msp430_dmem_rdhold (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rd_issue_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] dout_o
);

  logic        rd_pend_q;
  logic [15:0] hold_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q <= 1'b0;
      hold_q    <= 16'h0000;
    end else begin
      rd_pend_q <= rd_issue_i;
      if (rd_pend_q) begin
        hold_q <= mem_rdata_i;
      end
    end
  end

  assign dout_o = rd_pend_q ? mem_rdata_i : hold_q;

endmodule

// File: rtl/soc_msp430_dmem_arbiter.sv
// Two-requester arbiter sharing one single-port DMEM between PU0 and PU1.
// Zero added latency when uncontended; the losing core is stalled via its wait output.
// Round-robin with bounded burst ownership (MAX_BURST consecutive grants while the other waits).
// Ports:
//   mclk, puc_rst                      clock, synchronous active-high reset
//   dmemK_cen/wen/addr/din (in)        core K request (cen/wen low active, wen 2'b11 = read)
//   dmemK_dout, dmemK_wait (out)       core K read data and stall
//   dmem_cen/wen/addr/din (out)        to the DMEM macro
//   dmem_dout (in)                     from the DMEM macro, valid one cycle after a read
module soc_msp430_dmem_arbiter
  import soc_msp430_dmem_arb_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          mclk,
  input  logic          puc_rst,
  input  logic          dmem0_cen,
  input  logic [1:0]    dmem0_wen,
  input  logic [AW-1:0] dmem0_addr,
  input  logic [15:0]   dmem0_din,
  output logic [15:0]   dmem0_dout,
  output logic          dmem0_wait,
  input  logic          dmem1_cen,
  input  logic [1:0]    dmem1_wen,
  input  logic [AW-1:0] dmem1_addr,
  input  logic [15:0]   dmem1_din,
  output logic [15:0]   dmem1_dout,
  output logic          dmem1_wait,
  output logic          dmem_cen,
  output logic [1:0]    dmem_wen,
  output logic [AW-1:0] dmem_addr,
  output logic [15:0]   dmem_din,
  input  logic [15:0]   dmem_dout
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

  arb_state_t    st_q, st_d;
  logic          last_q, last_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  logic req0, req1;
  logic gnt0, gnt1;
  logic may_keep;

  assign req0     = ~dmem0_cen;
  assign req1     = ~dmem1_cen;
  assign may_keep = (burst_cnt_q < BurstLast);

  // State register
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      st_q        <= ARB_IDLE;
      last_q      <= 1'b1;  // so core 0 wins the first tie
      burst_cnt_q <= '0;
    end else begin
      st_q        <= st_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Grant decision
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!puc_rst) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (st_q == ARB_OWN0 && may_keep) begin
          gnt0 = 1'b1;
        end else if (st_q == ARB_OWN1 && may_keep) begin
          gnt1 = 1'b1;
        end else if (last_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end
    end
  end

  // Next state
  always_comb begin
    st_d        = ARB_IDLE;
    last_d      = last_q;
    burst_cnt_d = '0;
    if (gnt0) begin
      st_d   = ARB_OWN0;
      last_d = 1'b0;
      // Count only consecutive grants that keep the other core waiting
      if (st_q == ARB_OWN0 && req1) begin
        burst_cnt_d = (burst_cnt_q == BurstLast) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
    end else if (gnt1) begin
      st_d   = ARB_OWN1;
      last_d = 1'b1;
      if (st_q == ARB_OWN1 && req0) begin
        burst_cnt_d = (burst_cnt_q == BurstLast) ? burst_cnt_q : burst_cnt_q + 1'b1;
      end
    end
  end

  // Outputs: memory-port mux and stalls
  always_comb begin
    dmem_cen  = 1'b1;
    dmem_wen  = WEN_READ;
    dmem_addr = '0;
    dmem_din  = 16'h0000;
    if (gnt0) begin
      dmem_cen  = 1'b0;
      dmem_wen  = dmem0_wen;
      dmem_addr = dmem0_addr;
      dmem_din  = dmem0_din;
    end else if (gnt1) begin
      dmem_cen  = 1'b0;
      dmem_wen  = dmem1_wen;
      dmem_addr = dmem1_addr;
      dmem_din  = dmem1_din;
    end
    dmem0_wait = req0 & ~gnt0 & ~puc_rst;
    dmem1_wait = req1 & ~gnt1 & ~puc_rst;
  end

  soc_msp430_dmem_rdhold u_rdhold0 (
    .clk_i       (mclk),
    .rst_i       (puc_rst),
    .rd_issue_i  (gnt0 & (dmem0_wen == WEN_READ)),
    .mem_rdata_i (dmem_dout),
    .dout_o      (dmem0_dout)
  );

  soc_msp430_dmem_rdhold u_rdhold1 (
    .clk_i       (mclk),
    .rst_i       (puc_rst),
    .rd_issue_i  (gnt1 & (dmem1_wen == WEN_READ)),
    .mem_rdata_i (dmem_dout),
    .dout_o      (dmem1_dout)
  );

endmodule

// File: tb/tb_soc_msp430_dmem_arbiter.sv
module tb_soc_msp430_dmem_arbiter;

  localparam logic       H   = 1'b1;
  localparam logic       L   = 1'b0;
  localparam logic [1:0] RD  = 2'b11;
  localparam logic [9:0] A0  = 10'h000;
  localparam logic [15:0] Z  = 16'h0000;

  typedef struct {
    logic        rst;
    logic        cen0;
    logic [1:0]  wen0;
    logic [9:0]  addr0;
    logic [15:0] din0;
    logic        cen1;
    logic [1:0]  wen1;
    logic [9:0]  addr1;
    logic [15:0] din1;
    logic        e_cen;
    logic [1:0]  e_wen;
    logic [9:0]  e_addr;
    logic [15:0] e_din;
    logic        e_w0;
    logic        e_w1;
    logic [15:0] e_d0;
    logic [15:0] e_d1;
  } vec_t;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        dmem0_cen, dmem1_cen;
  logic [1:0]  dmem0_wen, dmem1_wen;
  logic [9:0]  dmem0_addr, dmem1_addr;
  logic [15:0] dmem0_din, dmem1_din;
  logic [15:0] dmem0_dout, dmem1_dout;
  logic        dmem0_wait, dmem1_wait;
  logic        dmem_cen;
  logic [1:0]  dmem_wen;
  logic [9:0]  dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;

  // Second instance with MAX_BURST=1 shares the core-side inputs
  logic [15:0] u1_dout0, u1_dout1;
  logic        u1_w0, u1_w1;
  logic        u1_cen;
  logic [1:0]  u1_wen;
  logic [9:0]  u1_addr;
  logic [15:0] u1_din;
  logic [15:0] u1_mem_dout = 16'h0000;

  logic [15:0] mem [0:1023];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 mclk = ~mclk;

  // Single-port DMEM macro model: registered read data, low-active byte enables
  always @(posedge mclk) begin
    if (!dmem_cen) begin
      if (dmem_wen == RD) begin
        dmem_dout <= mem[dmem_addr];
      end else begin
        if (!dmem_wen[0]) mem[dmem_addr][7:0]  <= dmem_din[7:0];
        if (!dmem_wen[1]) mem[dmem_addr][15:8] <= dmem_din[15:8];
      end
    end
  end

  soc_msp430_dmem_arbiter #(.AW(10), .MAX_BURST(4)) u_dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .dmem0_cen  (dmem0_cen),
    .dmem0_wen  (dmem0_wen),
    .dmem0_addr (dmem0_addr),
    .dmem0_din  (dmem0_din),
    .dmem0_dout (dmem0_dout),
    .dmem0_wait (dmem0_wait),
    .dmem1_cen  (dmem1_cen),
    .dmem1_wen  (dmem1_wen),
    .dmem1_addr (dmem1_addr),
    .dmem1_din  (dmem1_din),
    .dmem1_dout (dmem1_dout),
    .dmem1_wait (dmem1_wait),
    .dmem_cen   (dmem_cen),
    .dmem_wen   (dmem_wen),
    .dmem_addr  (dmem_addr),
    .dmem_din   (dmem_din),
    .dmem_dout  (dmem_dout)
  );

  soc_msp430_dmem_arbiter #(.AW(10), .MAX_BURST(1)) u_dut1 (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
    .dmem0_cen  (dmem0_cen),
    .dmem0_wen  (dmem0_wen),
    .dmem0_addr (dmem0_addr),
    .dmem0_din  (dmem0_din),
    .dmem0_dout (u1_dout0),
    .dmem0_wait (u1_w0),
    .dmem1_cen  (dmem1_cen),
    .dmem1_wen  (dmem1_wen),
    .dmem1_addr (dmem1_addr),
    .dmem1_din  (dmem1_din),
    .dmem1_dout (u1_dout1),
    .dmem1_wait (u1_w1),
    .dmem_cen   (u1_cen),
    .dmem_wen   (u1_wen),
    .dmem_addr  (u1_addr),
    .dmem_din   (u1_din),
    .dmem_dout  (u1_mem_dout)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    puc_rst    = v.rst;
    dmem0_cen  = v.cen0;
    dmem0_wen  = v.wen0;
    dmem0_addr = v.addr0;
    dmem0_din  = v.din0;
    dmem1_cen  = v.cen1;
    dmem1_wen  = v.wen1;
    dmem1_addr = v.addr1;
    dmem1_din  = v.din1;
  endtask

  // Drive at the falling edge, check combinational outputs before the next rising edge
  task automatic apply(input string tag, input vec_t v);
    @(negedge mclk);
    drive(v);
    #2;
    chk({tag, " cen"},  {15'd0, dmem_cen},   {15'd0, v.e_cen});
    chk({tag, " wen"},  {14'd0, dmem_wen},   {14'd0, v.e_wen});
    chk({tag, " addr"}, {6'd0, dmem_addr},   {6'd0, v.e_addr});
    chk({tag, " din"},  dmem_din,            v.e_din);
    chk({tag, " wait0"}, {15'd0, dmem0_wait}, {15'd0, v.e_w0});
    chk({tag, " wait1"}, {15'd0, dmem1_wait}, {15'd0, v.e_w1});
    chk({tag, " dout0"}, dmem0_dout,         v.e_d0);
    chk({tag, " dout1"}, dmem1_dout,         v.e_d1);
  endtask

  task automatic do_reset();
    vec_t v;
    v = '{H, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, Z,Z};
    @(negedge mclk);
    drive(v);
    @(negedge mclk);
    @(negedge mclk);
    v.rst = L;
    drive(v);
  endtask

  vec_t vecs [14];
  vec_t idle_v;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[10'h010] = 16'hA5A5;
    mem[10'h020] = 16'h1234;
    mem[10'h030] = 16'h5555;
    mem[10'h040] = 16'h6666;
    dmem_dout = 16'h0000;

    // {rst, cen0,wen0,addr0,din0, cen1,wen1,addr1,din1, e_cen,e_wen,e_addr,e_din, e_w0,e_w1, d0,d1}
    vecs[0]  = '{H, L,RD,10'h010,Z, L,RD,10'h030,Z, H,RD,A0,Z, L,L, Z,Z};
    vecs[1]  = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, Z,Z};
    vecs[2]  = '{L, L,RD,10'h020,Z, L,RD,10'h030,Z, L,RD,10'h020,Z, L,H, Z,Z};
    vecs[3]  = '{L, H,RD,A0,Z, L,RD,10'h030,Z, L,RD,10'h030,Z, L,L, 16'h1234,Z};
    vecs[4]  = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, 16'h1234,16'h5555};
    vecs[5]  = '{L, L,RD,10'h010,Z, H,RD,A0,Z, L,RD,10'h010,Z, L,L, 16'h1234,16'h5555};
    vecs[6]  = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, 16'hA5A5,16'h5555};
    vecs[7]  = '{L, L,RD,10'h020,Z, H,RD,A0,Z, L,RD,10'h020,Z, L,L, 16'hA5A5,16'h5555};
    vecs[8]  = '{L, H,RD,A0,Z, L,2'b00,10'h020,16'hBEEF, L,2'b00,10'h020,16'hBEEF, L,L,
                 16'h1234,16'h5555};
    vecs[9]  = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, 16'h1234,16'h5555};
    vecs[10] = '{L, L,RD,10'h020,Z, H,RD,A0,Z, L,RD,10'h020,Z, L,L, 16'h1234,16'h5555};
    vecs[11] = '{L, H,RD,A0,Z, L,2'b10,10'h020,16'h0011, L,2'b10,10'h020,16'h0011, L,L,
                 16'hBEEF,16'h5555};
    vecs[12] = '{L, H,RD,A0,Z, L,RD,10'h020,Z, L,RD,10'h020,Z, L,L, 16'hBEEF,16'h5555};
    vecs[13] = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, 16'hBEEF,16'hBE11};
    idle_v   = '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, Z,Z};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Continuous contention: MAX_BURST=4 gives 0,0,0,0,1,1,1,1,0,0; MAX_BURST=1 alternates
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic e_g0_b4, e_g0_b1;
      vec_t v;
      v = '{L, L,RD,10'h010,Z, L,RD,10'h030,Z, L,RD,A0,Z, L,L, Z,Z};
      e_g0_b4 = ((i % 8) < 4);
      e_g0_b1 = ((i % 2) == 0);
      @(negedge mclk);
      drive(v);
      #2;
      chk($sformatf("burst4 c%0d wait1", i), {15'd0, dmem1_wait}, {15'd0, e_g0_b4});
      chk($sformatf("burst4 c%0d wait0", i), {15'd0, dmem0_wait}, {15'd0, ~e_g0_b4});
      chk($sformatf("burst1 c%0d wait1", i), {15'd0, u1_w1}, {15'd0, e_g0_b1});
      chk($sformatf("burst1 c%0d wait0", i), {15'd0, u1_w0}, {15'd0, ~e_g0_b1});
    end

    // Reset drops a pending PU1 read and clears holds; next tie goes to PU0
    do_reset();
    apply("rst c1", '{L, H,RD,A0,Z, L,RD,10'h040,Z, L,RD,10'h040,Z, L,L, Z,Z});
    apply("rst c2", '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, Z,16'h6666});
    apply("rst c3", '{L, H,RD,A0,Z, L,RD,10'h030,Z, L,RD,10'h030,Z, L,L, Z,16'h6666});
    @(negedge mclk);
    drive('{H, L,RD,10'h010,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, Z,Z});
    #2;
    chk("rst c4 cen", {15'd0, dmem_cen}, 16'h0001);
    chk("rst c4 wen", {14'd0, dmem_wen}, 16'h0003);
    chk("rst c4 wait0", {15'd0, dmem0_wait}, 16'h0000);
    chk("rst c4 wait1", {15'd0, dmem1_wait}, 16'h0000);
    apply("rst c5", idle_v);
    apply("rst c6", '{L, L,RD,10'h010,Z, L,RD,10'h040,Z, L,RD,10'h010,Z, L,H, Z,Z});
    apply("rst c7", '{L, H,RD,A0,Z, H,RD,A0,Z, H,RD,A0,Z, L,L, 16'hA5A5,Z});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
